cache_fill_arbiter: RTL
=======================

# cache_fill_arbiter

Multi-cycle main-memory controller shared by the I-cache and D-cache miss handlers of the five-stage pipeline. It arbitrates between an instruction-block miss, a data-block miss and a write-through store. It sequences the 8-word block fill and steers returned words into the requesting cache. While either cache waits, fetch and decode stall on that cache's miss signal; this block only owns the memory port.

## Interface
- `WORDS`, 8: words per cache block; 16-bit words, so 16-byte blocks.
- `ADDR_W`, 16: byte-address width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `i_miss`  in  1  I-cache miss request; held high until `i_fill_done`.
- `i_miss_addr`  in  16  I-cache miss byte address.
- `d_miss`  in  1  D-cache miss request; held high until `d_fill_done`.
- `d_miss_addr`  in  16  D-cache miss byte address.
- `d_wr_req`  in  1  write-through store request; held high until `d_wr_ack`.
- `d_wr_addr`  in  16  store byte address.
- `d_wr_data`  in  16  store data.
- `mem_en`  out  1  memory access strobe, one per word.
- `mem_wr`  out  1  1 = write, 0 = read.
- `mem_addr`  out  16  memory byte address.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data.
- `mem_rvalid`  in  1  `mem_rdata` valid; the memory is pipelined and returns data in issue order.
- `fill_data`  out  16  returned word, equal to `mem_rdata`.
- `fill_idx`  out  3  word index within the block of `fill_data`.
- `fill_we_i`  out  1  write `fill_data` into the I-cache data array.
- `fill_we_d`  out  1  write `fill_data` into the D-cache data array.
- `i_fill_done`  out  1  one-cycle pulse; I-block complete and tag may be written.
- `d_fill_done`  out  1  one-cycle pulse; D-block complete.
- `d_wr_ack`  out  1  one-cycle pulse; store issued.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, WRITE, FILL, DONE.
- **IDLE selection.** Requests are sampled each cycle and the highest priority wins:
  - `d_wr_req` goes to WRITE.
  - Otherwise `d_miss` and/or `i_miss` go to FILL, with the owner chosen per Configuration.
  - The owner is latched. `base` is latched as the miss address with bits [3:0] cleared.
- **WRITE (one cycle).**
  - `mem_en=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_wdata=d_wr_data`, `d_wr_ack=1`.
  - Next state is IDLE.
- **FILL.**
  - Issue counter `icnt` runs 0..WORDS.
  - While `icnt<WORDS`: `mem_en=1`, `mem_wr=0`, `mem_addr={base[15:4], icnt[2:0], 1'b0}`, then `icnt` increments.
  - Return counter `rcnt` counts `mem_rvalid`. On each rvalid: `fill_idx=rcnt[2:0]`, and `fill_we_i` or `fill_we_d` is high according to the owner.
  - When the rvalid occurs with `rcnt==WORDS-1`, the next state is DONE.
- **DONE (one cycle).**
  - Pulse the owner's `*_fill_done`.
  - Clear `icnt`, `rcnt` and owner; next state is IDLE.
  - The requester drops its request in the cycle after the pulse. Because DONE always returns to IDLE, a still-high request is only sampled one cycle later.
- **Ignored rvalids.** `mem_rvalid` outside FILL, or beyond WORDS returns, is ignored: no fill write and no counter change.
- **Idle outputs.** Outside the cases above, `mem_en`, `mem_wr`, all `fill_we_*` and all pulses are 0. `mem_addr`, `mem_wdata` and `fill_idx` hold 0.

## Timing
- **Reset values.** Asynchronous `rst` forces state IDLE, `icnt=rcnt=0`, owner cleared, round-robin pointer = D, and all outputs 0.
- **Reset mid-fill.** The fill is abandoned. Data still in flight returns while in IDLE and is ignored. The requester's held request restarts the fill from word 0.
- **Latency.** Request seen in IDLE at cycle t:
  - First `mem_en` at t+1; last issue at t+WORDS.
  - `*_fill_done` one cycle after the final rvalid.
  - With memory latency L: done at t+WORDS+L+1.
  - Store: `d_wr_ack` at t+1.
- **Control signals.** `mem_en` / `mem_wr` / `mem_addr` / `fill_we_*` are combinational from state and counters. `fill_data` is combinational from `mem_rdata`.
- **Simultaneous events.**
  - An rvalid may arrive during issue cycles; both counters advance independently.
  - A store requested mid-fill waits for IDLE.

## Configuration
- `ARB_ROUND_ROBIN_EN`, undefined: fixed priority, store > D-miss > I-miss.
- `ARB_ROUND_ROBIN_EN`, defined: store keeps top priority. When `d_miss` and `i_miss` are both high in IDLE, the grant goes to the pointer side. After each fill, the pointer flips to the side that did not own the fill.
- A lone miss is granted immediately in both builds.

## Test plan
- **I-miss.** `i_miss=1`, `i_miss_addr=0x1236`, memory L=4:
  - `mem_addr` = 0x1230, 0x1232 … 0x123E on 8 consecutive cycles.
  - `fill_we_i` with `fill_idx` 0..7.
  - `i_fill_done` exactly 13 cycles after the request cycle.
- **Store vs miss.** `d_wr_req` (addr 0x0040, data 0xBEEF) and `d_miss` (0x0050) in the same cycle:
  - WRITE first: `mem_wr=1`, `d_wr_ack` pulse.
  - Then fill reads of 0x0050..0x005E with `fill_we_d`.
- **Both misses, fixed priority.** `d_miss=1` and `i_miss=1` together:
  - Without macro: D filled first, I filled immediately after.
  - With macro, issued twice back-to-back: grant order D, I, D, I.
- **Reset mid-fill.** Assert `rst` after 3 returned words, release, keep `i_miss` high:
  - Outputs are 0 during reset.
  - Late rvalids produce no `fill_we_i`.
  - The fill restarts at word 0 and completes normally.
- **Stray returns.** Inject 2 extra `mem_rvalid` in IDLE and 1 after the 8th return:
  - No fill writes and no done pulses.
  - Counters stay 0.
- **Late memory.** Memory with L=1 and L=7: all 8 words arrive in order and `done` is asserted at request+WORDS+L+1.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shared main-memory port for I/D block fills and stores.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin I/D miss grants.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   i_miss/_addr        I-cache block miss request and byte address
//   d_miss/_addr        D-cache block miss request and byte address
//   d_wr_req/addr/data  write-through store request
//   mem_en/wr/addr/wdata  memory command port (one strobe per word)
//   mem_rdata/rvalid    in-order memory read return
//   fill_data/idx       returned word and its index within the block
//   fill_we_i/d         write strobe into I- or D-cache data array
//   i/d_fill_done       one-cycle block-complete pulses
//   d_wr_ack            one-cycle store-issued pulse
//   busy                controller not idle
module cache_fill_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_miss,
  input  logic [ADDR_W-1:0]          i_miss_addr,
  input  logic                       d_miss,
  input  logic [ADDR_W-1:0]          d_miss_addr,
  input  logic                       d_wr_req,
  input  logic [ADDR_W-1:0]          d_wr_addr,
  input  logic [15:0]                d_wr_data,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic [15:0]                mem_rdata,
  input  logic                       mem_rvalid,
  output logic [15:0]                fill_data,
  output logic [$clog2(WORDS)-1:0]   fill_idx,
  output logic                       fill_we_i,
  output logic                       fill_we_d,
  output logic                       i_fill_done,
  output logic                       d_fill_done,
  output logic                       d_wr_ack,
  output logic                       busy
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] N_WORDS = CW'(WORDS);
  localparam logic [CW-1:0] LAST    = CW'(WORDS - 1);
  // Clears the byte-in-block bits (16-byte blocks by default).
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     icnt_q, icnt_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic              owner_q, owner_d;   // 1 = I-cache, 0 = D-cache
  logic [ADDR_W-1:0] base_q, base_d;
  logic              grant_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_i_q, rr_i_d;                  // 1 = I side wins a tie

  // Tie goes to the pointer side; a lone miss always wins.
  assign grant_i = i_miss & (~d_miss | rr_i_q);

  always_comb begin
    rr_i_d = rr_i_q;
    if (state_q == S_DONE) rr_i_d = ~owner_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_i_q <= 1'b0;
    else     rr_i_q <= rr_i_d;
  end
`else
  assign grant_i = ~d_miss;
`endif

  assign fill_data = mem_rdata;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    rcnt_d      = rcnt_q;
    owner_d     = owner_q;
    base_d      = base_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_idx    = '0;
    fill_we_i   = 1'b0;
    fill_we_d   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (d_wr_req) begin
          state_d = S_WRITE;
        end else if (d_miss | i_miss) begin
          state_d = S_FILL;
          owner_d = grant_i;
          base_d  = (grant_i ? i_miss_addr : d_miss_addr) & BLK_MASK;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = S_IDLE;
      end
      S_FILL: begin
        // Issue and return sides advance independently.
        if (icnt_q < N_WORDS) begin
          mem_en   = 1'b1;
          mem_addr = base_q | ADDR_W'({icnt_q[IW-1:0], 1'b0});
          icnt_d   = icnt_q + CW'(1);
        end
        if (mem_rvalid && (rcnt_q < N_WORDS)) begin
          fill_idx  = rcnt_q[IW-1:0];
          fill_we_i = owner_q;
          fill_we_d = ~owner_q;
          rcnt_d    = rcnt_q + CW'(1);
          if (rcnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        i_fill_done = owner_q;
        d_fill_done = ~owner_q;
        icnt_d      = '0;
        rcnt_d      = '0;
        owner_d     = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      owner_q <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

endmodule
